// File: rtl/aes_block_loader.sv
// Byte-serial front end for AES_Encryption: assembles a 128-bit plaintext and key from a byte stream.
// Define AES_LOADER_KEY_REUSE_EN to add the KEY_HOLD port and data-only frames that keep the key.
module aes_block_loader #(
    parameter int unsigned ABORT_CYCLES = 1024
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [7:0]   BYTE_IN,
    input  logic         BYTE_VALID,
    output logic         BYTE_READY,
`ifdef AES_LOADER_KEY_REUSE_EN
    input  logic         KEY_HOLD,
`endif
    output logic [0:127] DATA,
    output logic [0:127] CIPHER_KEY,
    output logic         BLOCK_VALID,
    input  logic         BLOCK_ACCEPT,
    output logic         FRAME_ABORT
);

    localparam int unsigned IDLE_W = (ABORT_CYCLES > 0) ? $clog2(ABORT_CYCLES + 1) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST =
        (ABORT_CYCLES > 0) ? IDLE_W'(ABORT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {StLoadData, StLoadKey, StPresent} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic              xfer;
    logic              last_byte;
    logic              in_frame;
    logic              expire;
    logic              skip_key;

`ifdef AES_LOADER_KEY_REUSE_EN
    logic key_hold_q;
    assign skip_key = key_hold_q;
`else
    assign skip_key = 1'b0;
`endif

    assign xfer      = BYTE_VALID & BYTE_READY;
    assign last_byte = (cnt == 4'd15);
    // A frame is in flight once any byte has landed: always in LoadKey, cnt > 0 in LoadData.
    assign in_frame  = (state == StLoadKey) || ((state == StLoadData) && (cnt != 4'd0));
    // Expiry is the idle cycle that would bring the counter to ABORT_CYCLES; a transfer blocks it.
    assign expire    = (ABORT_CYCLES != 0) && in_frame && !xfer && (idle_cnt == IDLE_LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= StLoadData;
            cnt         <= '0;
            idle_cnt    <= '0;
            BYTE_READY  <= 1'b0;
            BLOCK_VALID <= 1'b0;
            FRAME_ABORT <= 1'b0;
            DATA        <= '0;
            CIPHER_KEY  <= '0;
`ifdef AES_LOADER_KEY_REUSE_EN
            key_hold_q  <= 1'b0;
`endif
        end else begin
            FRAME_ABORT <= 1'b0;
            if (expire) begin
                state       <= StLoadData;
                cnt         <= '0;
                idle_cnt    <= '0;
                FRAME_ABORT <= 1'b1;
                BYTE_READY  <= 1'b1;
                BLOCK_VALID <= 1'b0;
            end else begin
                if (xfer || !in_frame) begin
                    idle_cnt <= '0;
                end else if ((ABORT_CYCLES != 0) && (idle_cnt != '1)) begin
                    idle_cnt <= idle_cnt + IDLE_W'(1);
                end

                unique case (state)
                    StLoadData: begin
                        BYTE_READY <= 1'b1;
                        if (xfer) begin
                            DATA[{cnt, 3'b000} +: 8] <= BYTE_IN;
`ifdef AES_LOADER_KEY_REUSE_EN
                            if (cnt == 4'd0) begin
                                key_hold_q <= KEY_HOLD;
                            end
`endif
                            if (last_byte) begin
                                cnt <= '0;
                                if (skip_key) begin
                                    state       <= StPresent;
                                    BYTE_READY  <= 1'b0;
                                    BLOCK_VALID <= 1'b1;
                                end else begin
                                    state <= StLoadKey;
                                end
                            end else begin
                                cnt <= cnt + 4'd1;
                            end
                        end
                    end
                    StLoadKey: begin
                        BYTE_READY <= 1'b1;
                        if (xfer) begin
                            CIPHER_KEY[{cnt, 3'b000} +: 8] <= BYTE_IN;
                            if (last_byte) begin
                                cnt         <= '0;
                                state       <= StPresent;
                                BYTE_READY  <= 1'b0;
                                BLOCK_VALID <= 1'b1;
                            end else begin
                                cnt <= cnt + 4'd1;
                            end
                        end
                    end
                    StPresent: begin
                        if (BLOCK_ACCEPT) begin
                            state       <= StLoadData;
                            cnt         <= '0;
                            BYTE_READY  <= 1'b1;
                            BLOCK_VALID <= 1'b0;
                        end
                    end
                    default: begin
                        state <= StLoadData;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aes_block_loader.sv
// Scoreboard bench for aes_block_loader: frames are queued as driven and checked when presented.
`timescale 1ns/1ps
module tb_aes_block_loader;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic [7:0]   BYTE_IN = 8'h00;
    logic         BYTE_VALID = 1'b0;
    logic         BYTE_READY;
    logic [0:127] DATA;
    logic [0:127] CIPHER_KEY;
    logic         BLOCK_VALID;
    logic         BLOCK_ACCEPT = 1'b0;
    logic         FRAME_ABORT;
`ifdef AES_LOADER_KEY_REUSE_EN
    logic         KEY_HOLD = 1'b0;
`endif

    int     n_checks = 0;
    int     n_fail = 0;
    int     abort_seen = 0;
    longint cyc = 0;

    typedef struct packed {
        logic [127:0] d;
        logic [127:0] k;
    } blk_t;
    blk_t sb[$];

    localparam logic [127:0] PT  = 128'h3243F6A8885A308D313198A2E0370734;
    localparam logic [127:0] KEY = 128'h2B7E151628AED2A6ABF7158809CF4F3C;

    aes_block_loader #(.ABORT_CYCLES(1024)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .BYTE_IN      (BYTE_IN),
        .BYTE_VALID   (BYTE_VALID),
        .BYTE_READY   (BYTE_READY),
`ifdef AES_LOADER_KEY_REUSE_EN
        .KEY_HOLD     (KEY_HOLD),
`endif
        .DATA         (DATA),
        .CIPHER_KEY   (CIPHER_KEY),
        .BLOCK_VALID  (BLOCK_VALID),
        .BLOCK_ACCEPT (BLOCK_ACCEPT),
        .FRAME_ABORT  (FRAME_ABORT)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;
    always @(negedge CLK) if (FRAME_ABORT === 1'b1) abort_seen <= abort_seen + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called just after a negedge; returns just after the negedge following the transfer.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        BYTE_IN    = b;
        BYTE_VALID = 1'b1;
        while (BYTE_READY !== 1'b1 && n < 64) begin
            @(negedge CLK);
            n++;
        end
        n_checks++;
        if (BYTE_READY !== 1'b1) begin
            n_fail++;
            $display("FAIL byte_ready: BYTE_READY=%b required 1 for byte %h", BYTE_READY, b);
        end
        @(negedge CLK);
        BYTE_VALID = 1'b0;
    endtask

    task automatic send_frame(input logic [127:0] d, input logic [127:0] k, input int gap_max,
                              input int long_gap, input bit data_only);
        int gap;
        logic [7:0] b;
        for (int i = 0; i < (data_only ? 16 : 32); i++) begin
            gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            if (i == 20) gap = long_gap;
            repeat (gap) @(negedge CLK);
            b = (i < 16) ? d[127-8*i -: 8] : k[127-8*(i-16) -: 8];
            send_byte(b);
        end
    endtask

    task automatic do_accept();
        BLOCK_ACCEPT = 1'b1;
        @(negedge CLK);
        BLOCK_ACCEPT = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        RST = 1'b1;
        #1;
        n_checks++;
        if (BYTE_READY !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b required 0", BYTE_READY); end
        n_checks++;
        if (BLOCK_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 0", BLOCK_VALID); end
        n_checks++;
        if (FRAME_ABORT !== 1'b0) begin n_fail++; $display("FAIL reset_abort: got %b required 0", FRAME_ABORT); end
        n_checks++;
        if (DATA !== 128'h0) begin n_fail++; $display("FAIL reset_data: got %h required 0", DATA); end
        n_checks++;
        if (CIPHER_KEY !== 128'h0) begin n_fail++; $display("FAIL reset_key: got %h required 0", CIPHER_KEY); end
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        n_checks++;
        if (BYTE_READY !== 1'b0) begin n_fail++; $display("FAIL reset_ready_hold: got %b required 0", BYTE_READY); end
        @(negedge CLK);
        n_checks++;
        if (BYTE_READY !== 1'b1) begin n_fail++; $display("FAIL reset_ready_rise: got %b required 1", BYTE_READY); end
    endtask

    task automatic test_full_frame();
        blk_t exp;
        sb.push_back('{d: PT, k: KEY});
        send_frame(PT, KEY, 0, 0, 1'b0);
        exp = sb.pop_front();
        n_checks++;
        if (BLOCK_VALID !== 1'b1) begin n_fail++; $display("FAIL full_valid: got %b required 1", BLOCK_VALID); end
        n_checks++;
        if (BYTE_READY !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b required 0", BYTE_READY); end
        n_checks++;
        if (DATA !== exp.d) begin n_fail++; $display("FAIL full_data: got %h required %h", DATA, exp.d); end
        n_checks++;
        if (CIPHER_KEY !== exp.k) begin n_fail++; $display("FAIL full_key: got %h required %h", CIPHER_KEY, exp.k); end
    endtask

    task automatic test_backpressure();
        BYTE_IN    = 8'hFF;
        BYTE_VALID = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            n_checks++;
            if (BLOCK_VALID !== 1'b1 || BYTE_READY !== 1'b0 || DATA !== PT || CIPHER_KEY !== KEY) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d: valid=%b ready=%b data=%h key=%h required 1 0 %h %h",
                         i, BLOCK_VALID, BYTE_READY, DATA, CIPHER_KEY, PT, KEY);
            end
        end
        BYTE_VALID = 1'b0;
        do_accept();
        n_checks++;
        if (BLOCK_VALID !== 1'b0) begin n_fail++; $display("FAIL bp_valid_drop: got %b required 0", BLOCK_VALID); end
        n_checks++;
        if (BYTE_READY !== 1'b1) begin n_fail++; $display("FAIL bp_ready_rise: got %b required 1", BYTE_READY); end
        n_checks++;
        if (DATA !== PT) begin n_fail++; $display("FAIL bp_no_consume: got %h required %h", DATA, PT); end
    endtask

    task automatic test_gappy();
        blk_t exp;
        int a0;
        a0 = abort_seen;
        sb.push_back('{d: PT, k: KEY});
        // A 1023-cycle gap is the longest that must not abort.
        send_frame(PT, KEY, 6, 1023, 1'b0);
        exp = sb.pop_front();
        n_checks++;
        if (BLOCK_VALID !== 1'b1) begin n_fail++; $display("FAIL gappy_valid: got %b required 1", BLOCK_VALID); end
        n_checks++;
        if (DATA !== exp.d) begin n_fail++; $display("FAIL gappy_data: got %h required %h", DATA, exp.d); end
        n_checks++;
        if (CIPHER_KEY !== exp.k) begin n_fail++; $display("FAIL gappy_key: got %h required %h", CIPHER_KEY, exp.k); end
        n_checks++;
        if (abort_seen != a0) begin n_fail++; $display("FAIL gappy_abort: got %0d pulses required 0", abort_seen - a0); end
        do_accept();
    endtask

    task automatic test_timeout();
        blk_t exp;
        int a0;
        int n;
        logic [127:0] d2, k2;
        d2 = 128'h00112233445566778899AABBCCDDEEFF;
        k2 = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
        a0 = abort_seen;
        for (int i = 0; i < 5; i++) send_byte(8'(8'hA0 + i));
        n = 0;
        while (FRAME_ABORT !== 1'b1 && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        n_checks++;
        if (n != 1024) begin n_fail++; $display("FAIL timeout_delay: abort after %0d idle cycles required 1024", n); end
        @(negedge CLK);
        n_checks++;
        if (FRAME_ABORT !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse_width: got %b required 0", FRAME_ABORT); end
        n_checks++;
        if (BYTE_READY !== 1'b1) begin n_fail++; $display("FAIL timeout_ready: got %b required 1", BYTE_READY); end
        repeat (50) @(negedge CLK);
        n_checks++;
        if (abort_seen - a0 != 1) begin n_fail++; $display("FAIL timeout_count: got %0d pulses required 1", abort_seen - a0); end
        sb.push_back('{d: d2, k: k2});
        // Accept outside PRESENT must be ignored while this frame loads.
        BLOCK_ACCEPT = 1'b1;
        send_frame(d2, k2, 0, 0, 1'b0);
        BLOCK_ACCEPT = 1'b0;
        exp = sb.pop_front();
        n_checks++;
        if (BLOCK_VALID !== 1'b1) begin n_fail++; $display("FAIL timeout_next_valid: got %b required 1", BLOCK_VALID); end
        n_checks++;
        if (DATA !== exp.d) begin n_fail++; $display("FAIL timeout_next_data: got %h required %h", DATA, exp.d); end
        n_checks++;
        if (CIPHER_KEY !== exp.k) begin n_fail++; $display("FAIL timeout_next_key: got %h required %h", CIPHER_KEY, exp.k); end
        do_accept();
    endtask

    task automatic test_reset_mid_key();
        blk_t exp;
        int a0;
        logic [127:0] d3, k3;
        d3 = {$urandom, $urandom, $urandom, $urandom};
        k3 = {$urandom, $urandom, $urandom, $urandom};
        a0 = abort_seen;
        for (int i = 0; i < 20; i++) send_byte(8'(8'h40 + i));
        #2;
        RST = 1'b1;
        #1;
        n_checks++;
        if (BYTE_READY !== 1'b0 || BLOCK_VALID !== 1'b0 || FRAME_ABORT !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_ctrl: ready=%b valid=%b abort=%b required 0 0 0",
                     BYTE_READY, BLOCK_VALID, FRAME_ABORT);
        end
        n_checks++;
        if (DATA !== 128'h0 || CIPHER_KEY !== 128'h0) begin
            n_fail++;
            $display("FAIL midrst_regs: data=%h key=%h required 0 0", DATA, CIPHER_KEY);
        end
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        sb.push_back('{d: d3, k: k3});
        send_frame(d3, k3, 2, 0, 1'b0);
        exp = sb.pop_front();
        n_checks++;
        if (BLOCK_VALID !== 1'b1) begin n_fail++; $display("FAIL midrst_valid: got %b required 1", BLOCK_VALID); end
        n_checks++;
        if (DATA !== exp.d) begin n_fail++; $display("FAIL midrst_data: got %h required %h", DATA, exp.d); end
        n_checks++;
        if (CIPHER_KEY !== exp.k) begin n_fail++; $display("FAIL midrst_key: got %h required %h", CIPHER_KEY, exp.k); end
        n_checks++;
        if (abort_seen != a0) begin n_fail++; $display("FAIL midrst_abort: got %0d pulses required 0", abort_seen - a0); end
        do_accept();
    endtask

    task automatic test_back_to_back();
        blk_t exp;
        longint t1;
        logic [127:0] d4, k4;
        sb.push_back('{d: KEY, k: PT});
        send_frame(KEY, PT, 0, 0, 1'b0);
        t1 = cyc;
        exp = sb.pop_front();
        n_checks++;
        if (DATA !== exp.d || CIPHER_KEY !== exp.k) begin
            n_fail++;
            $display("FAIL b2b_first: data=%h key=%h required %h %h", DATA, CIPHER_KEY, exp.d, exp.k);
        end
        do_accept();
        n_checks++;
        if (BYTE_READY !== 1'b1 || BLOCK_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_accept: ready=%b valid=%b required 1 0", BYTE_READY, BLOCK_VALID);
        end
        d4 = {$urandom, $urandom, $urandom, $urandom};
        k4 = {$urandom, $urandom, $urandom, $urandom};
        sb.push_back('{d: d4, k: k4});
        send_frame(d4, k4, 0, 0, 1'b0);
        exp = sb.pop_front();
        n_checks++;
        if (BLOCK_VALID !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b required 1", BLOCK_VALID); end
        n_checks++;
        if (cyc - t1 != 33) begin n_fail++; $display("FAIL b2b_period: got %0d cycles required 33", cyc - t1); end
        n_checks++;
        if (DATA !== exp.d || CIPHER_KEY !== exp.k) begin
            n_fail++;
            $display("FAIL b2b_second: data=%h key=%h required %h %h", DATA, CIPHER_KEY, exp.d, exp.k);
        end
        do_accept();
    endtask

`ifdef AES_LOADER_KEY_REUSE_EN
    task automatic test_key_reuse();
        blk_t exp;
        logic [127:0] kprev, d5;
        kprev = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
        d5    = 128'h000102030405060708090A0B0C0D0E0F;
        sb.push_back('{d: PT, k: kprev});
        send_frame(PT, kprev, 0, 0, 1'b0);
        exp = sb.pop_front();
        n_checks++;
        if (CIPHER_KEY !== exp.k) begin n_fail++; $display("FAIL reuse_first_key: got %h required %h", CIPHER_KEY, exp.k); end
        do_accept();
        sb.push_back('{d: d5, k: kprev});
        KEY_HOLD = 1'b1;
        send_frame(d5, 128'h0, 0, 0, 1'b1);
        KEY_HOLD = 1'b0;
        exp = sb.pop_front();
        n_checks++;
        if (BLOCK_VALID !== 1'b1) begin n_fail++; $display("FAIL reuse_valid: got %b required 1", BLOCK_VALID); end
        n_checks++;
        if (DATA !== exp.d) begin n_fail++; $display("FAIL reuse_data: got %h required %h", DATA, exp.d); end
        n_checks++;
        if (CIPHER_KEY !== exp.k) begin n_fail++; $display("FAIL reuse_key: got %h required %h", CIPHER_KEY, exp.k); end
        do_accept();
    endtask
`endif

    initial begin
        test_reset();
        test_full_frame();
        test_backpressure();
        test_gappy();
        test_timeout();
        test_reset_mid_key();
        test_back_to_back();
`ifdef AES_LOADER_KEY_REUSE_EN
        test_key_reuse();
`endif
        repeat (4) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
